// File: rtl/qea_run_sequencer.sv
// Host-side run controller for the QEA core: loads gate context, seeds the state RAM with a
// basis state, starts and times the run, then streams the final state vector out.
module qea_run_sequencer #(
  parameter int unsigned PE_NUM_WIDTH            = 2,
  parameter int unsigned PE_NUM                  = 4,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned STATE_DATA_WIDTH        = 64,
  parameter int unsigned STATE_ADDR_WIDTH        = 16,
  parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int unsigned MAX_QBIT_WIDTH          = 6,
  parameter int unsigned NUM_FRAC_BIT            = 30,
  parameter int unsigned RD_LATENCY              = 1,
  parameter int unsigned CYC_WIDTH               = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]              i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]       i_ins_num,
  input  logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] i_basis_idx,
  input  logic [CYC_WIDTH-1:0]                   i_timeout,
  input  logic                                   i_ctx_valid,
  output logic                                   o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]     i_ctx_data,
  output logic                                   o_ctx_en,
  output logic                                   o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]     o_ctx_data,
  output logic [PE_NUM-1:0]                      o_state_ena,
  output logic [PE_NUM-1:0]                      o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]            o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]     o_state_dina,
  output logic                                   o_start,
  input  logic                                   i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]     i_state_dout,
  output logic                                   o_rd_valid,
  input  logic                                   i_rd_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]     o_rd_data,
  output logic                                   o_rd_last,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic [1:0]                             o_err,
  output logic [CYC_WIDTH-1:0]                   o_run_cycles
);

  localparam int unsigned KW     = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int unsigned KM_W   = KW + 1;
  localparam int unsigned WCNT_W = STATE_ADDR_WIDTH + 1;
  localparam int unsigned ICNT_W = GATE_CONTEXT_ADDR_WIDTH + 1;
  localparam int unsigned WORD_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int unsigned LAT_W  = $clog2(RD_LATENCY + 1);

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrQbit    = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;

  localparam logic [DATA_WIDTH-1:0]       OneReal = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  localparam logic [STATE_DATA_WIDTH-1:0] AmpOne  = {OneReal, {DATA_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StLoadCtx,
    StLoadState,
    StStart,
    StRun,
    StIssue,
    StWait,
    StOut
  } state_e;

  state_e                      state;
  logic [ICNT_W-1:0]           ins_num;
  logic [ICNT_W-1:0]           ctx_cnt;
  logic [STATE_ADDR_WIDTH-1:0] last_addr;
  logic [STATE_ADDR_WIDTH-1:0] word_addr;
  logic [STATE_ADDR_WIDTH-1:0] basis_addr;
  logic [PE_NUM_WIDTH-1:0]     basis_lane;
  logic [LAT_W-1:0]            lat_cnt;

  // Decode of the run request, only consumed in IDLE.
  logic                      qbit_bad;
  logic [MAX_QBIT_WIDTH-1:0] addr_bits;
  logic [WCNT_W-1:0]         word_count;
  logic [KM_W-1:0]           k_mask;
  logic [KW-1:0]             k_trunc;

  always_comb begin
    qbit_bad   = (i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) ||
                 (i_qbit_num > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH));
    addr_bits  = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    word_count = WCNT_W'(1) << addr_bits;
    k_mask     = (KM_W'(1) << i_qbit_num) - KM_W'(1);
    k_trunc    = i_basis_idx & k_mask[KW-1:0];
  end

  // Lane 0 sits in the most significant amplitude slice.
  logic [WORD_W-1:0] init_word;

  always_comb begin
    init_word = '0;
    for (int l = 0; l < int'(PE_NUM); l++) begin
      if (PE_NUM_WIDTH'(l) == basis_lane) begin
        init_word[(int'(PE_NUM) - l) * int'(STATE_DATA_WIDTH) - 1 -: STATE_DATA_WIDTH] = AmpOne;
      end
    end
  end

  logic [CYC_WIDTH-1:0] run_cycles_inc;
  assign run_cycles_inc = o_run_cycles + CYC_WIDTH'(1);

  assign o_busy      = (state != StIdle);
  assign o_ctx_ready = (state == StLoadCtx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      ins_num       <= '0;
      ctx_cnt       <= '0;
      last_addr     <= '0;
      word_addr     <= '0;
      basis_addr    <= '0;
      basis_lane    <= '0;
      lat_cnt       <= '0;
      o_ctx_en      <= 1'b0;
      o_ctx_wea     <= 1'b0;
      o_ctx_addr    <= '0;
      o_ctx_data    <= '0;
      o_state_ena   <= '0;
      o_state_wea   <= '0;
      o_state_addra <= '0;
      o_state_dina  <= '0;
      o_start       <= 1'b0;
      o_rd_valid    <= 1'b0;
      o_rd_data     <= '0;
      o_rd_last     <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= ErrNone;
      o_run_cycles  <= '0;
    end else begin
      o_ctx_en    <= 1'b0;
      o_ctx_wea   <= 1'b0;
      o_state_ena <= '0;
      o_state_wea <= '0;
      o_start     <= 1'b0;
      o_done      <= 1'b0;

      unique case (state)
        StIdle: begin
          if (i_go) begin
            if (qbit_bad) begin
              o_err <= ErrQbit;
            end else begin
              o_err      <= ErrNone;
              ins_num    <= i_ins_num;
              ctx_cnt    <= '0;
              word_addr  <= '0;
              last_addr  <= STATE_ADDR_WIDTH'(word_count - WCNT_W'(1));
              basis_addr <= k_trunc[KW-1:PE_NUM_WIDTH];
              basis_lane <= k_trunc[PE_NUM_WIDTH-1:0];
              state      <= (i_ins_num == '0) ? StLoadState : StLoadCtx;
            end
          end
        end

        StLoadCtx: begin
          if (i_ctx_valid) begin
            o_ctx_en   <= 1'b1;
            o_ctx_wea  <= 1'b1;
            o_ctx_addr <= ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
            o_ctx_data <= i_ctx_data;
            ctx_cnt    <= ctx_cnt + ICNT_W'(1);
            if (ctx_cnt == ins_num - ICNT_W'(1)) begin
              state <= StLoadState;
            end
          end
        end

        StLoadState: begin
          o_state_ena   <= '1;
          o_state_wea   <= '1;
          o_state_addra <= word_addr;
          o_state_dina  <= (word_addr == basis_addr) ? init_word : '0;
          if (word_addr == last_addr) begin
            word_addr <= '0;
            state     <= StStart;
          end else begin
            word_addr <= word_addr + STATE_ADDR_WIDTH'(1);
          end
        end

        StStart: begin
          o_start      <= 1'b1;
          o_run_cycles <= '0;
          state        <= StRun;
        end

        StRun: begin
          // A completion coinciding with the start pulse belongs to a stale run.
          if (i_complete && !o_start) begin
            state <= StIssue;
          end else begin
            o_run_cycles <= run_cycles_inc;
            if ((i_timeout != '0) && (run_cycles_inc == i_timeout)) begin
              o_err <= ErrTimeout;
              state <= StIdle;
            end
          end
        end

        StIssue: begin
          o_state_ena   <= '1;
          o_state_addra <= word_addr;
          lat_cnt       <= '0;
          state         <= StWait;
        end

        StWait: begin
          if (lat_cnt == LAT_W'(RD_LATENCY)) begin
            o_rd_data  <= i_state_dout;
            o_rd_valid <= 1'b1;
            o_rd_last  <= (word_addr == last_addr);
            state      <= StOut;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        StOut: begin
          if (i_rd_ready) begin
            o_rd_valid <= 1'b0;
            o_rd_last  <= 1'b0;
            if (o_rd_last) begin
              o_done <= 1'b1;
              state  <= StIdle;
            end else begin
              word_addr <= word_addr + STATE_ADDR_WIDTH'(1);
              state     <= StIssue;
            end
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_qea_run_sequencer.sv
// Directed bench for qea_run_sequencer: mock context/state RAMs, a QEA completion model and a
// readback consumer with selectable backpressure.
module tb_qea_run_sequencer;

  localparam logic [63:0] One = 64'h40000000_00000000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_go = 1'b0;
  logic [5:0]   i_qbit_num = '0;
  logic [16:0]  i_ins_num = '0;
  logic [17:0]  i_basis_idx = '0;
  logic [31:0]  i_timeout = '0;
  logic         i_ctx_valid = 1'b0;
  logic         o_ctx_ready;
  logic [63:0]  i_ctx_data = '0;
  logic         o_ctx_en, o_ctx_wea;
  logic [15:0]  o_ctx_addr;
  logic [63:0]  o_ctx_data;
  logic [3:0]   o_state_ena, o_state_wea;
  logic [15:0]  o_state_addra;
  logic [255:0] o_state_dina;
  logic         o_start;
  logic         i_complete = 1'b0;
  logic [255:0] i_state_dout;
  logic         o_rd_valid;
  logic         i_rd_ready = 1'b0;
  logic [255:0] o_rd_data;
  logic         o_rd_last, o_busy, o_done;
  logic [1:0]   o_err;
  logic [31:0]  o_run_cycles;

  qea_run_sequencer dut (
    .clk(clk), .rst(rst), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .i_basis_idx(i_basis_idx), .i_timeout(i_timeout), .i_ctx_valid(i_ctx_valid),
    .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data), .o_ctx_en(o_ctx_en),
    .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .o_start(o_start), .i_complete(i_complete),
    .i_state_dout(i_state_dout), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_rd_data(o_rd_data), .o_rd_last(o_rd_last), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_run_cycles(o_run_cycles)
  );

  always #5 clk = ~clk;

  wire any_out = |{o_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data, o_state_ena,
                   o_state_wea, o_state_addra, o_state_dina, o_start, o_rd_valid, o_rd_data,
                   o_rd_last, o_busy, o_done, o_err, o_run_cycles};

  int total = 0;
  int bad = 0;

  function automatic logic [63:0] ctx_word(input int i);
    logic [31:0] b;
    b = 32'(i);
    return {32'hC0DE_0000 ^ b, b * 32'h9E37_79B9};
  endfunction

  function automatic logic [255:0] qpat(input int i);
    logic [31:0] b;
    b = 32'(i);
    return {b ^ 32'h1111_0000, b + 32'h2200_0000, ~b, b << 4, b ^ 32'h0000_FFFF,
            b + 32'h77, 32'hA5A5_0000 | b, b * 32'd3};
  endfunction

  // Mock state RAM, one-cycle read latency; bd_req models the QEA rewriting the state vector.
  logic [255:0] smem [0:63];
  logic [255:0] rd_q = '0;
  logic         bd_req = 1'b0;
  always @(posedge clk) begin
    if (bd_req) begin
      for (int i = 0; i < 64; i++) smem[i] <= qpat(i);
    end else if (&o_state_ena && &o_state_wea) begin
      smem[o_state_addra[5:0]] <= o_state_dina;
    end
    if (|o_state_ena && !(|o_state_wea)) rd_q <= smem[o_state_addra[5:0]];
  end
  assign i_state_dout = rd_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: cumulative counters; tests compare deltas around each run.
  int ctx_wr_cnt = 0, ctx_base = 0, ctx_bad = 0, ctx_first_cyc = 0, ctx_last_cyc = 0;
  int st_wr_cnt = 0, st_base = 0, st_bad = 0, nz_cnt = 0;
  int start_cnt = 0, start_cyc = 0, done_cnt = 0, rdv_cnt = 0, err2_cyc = 0;
  logic err2_prev = 1'b0;
  logic [15:0]  nz_addr = '0;
  logic [255:0] nz_data = '0;
  always @(negedge clk) begin
    if (o_ctx_en && o_ctx_wea) begin
      if (ctx_wr_cnt == ctx_base) ctx_first_cyc = cyc;
      ctx_last_cyc = cyc;
      if (o_ctx_addr !== 16'(ctx_wr_cnt - ctx_base) ||
          o_ctx_data !== ctx_word(ctx_wr_cnt - ctx_base)) ctx_bad++;
      ctx_wr_cnt++;
    end
    if (&o_state_ena && &o_state_wea) begin
      if (o_state_addra !== 16'(st_wr_cnt - st_base)) st_bad++;
      if (o_state_dina != '0) begin
        nz_cnt++;
        nz_addr = o_state_addra;
        nz_data = o_state_dina;
      end
      st_wr_cnt++;
    end
    if (o_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (o_done) done_cnt++;
    if (o_rd_valid) rdv_cnt++;
    if (o_err == 2'd2 && !err2_prev) err2_cyc = cyc;
    err2_prev = (o_err == 2'd2);
  end

  int r_beats, r_data_bad, r_last_bad, r_stable_bad, r_hung;
  int s_ctx, s_ctxbad, s_st, s_stbad, s_nz, s_start, s_done, s_rdv;

  task automatic snap();
    s_ctx = ctx_wr_cnt; s_ctxbad = ctx_bad; s_st = st_wr_cnt; s_stbad = st_bad;
    s_nz = nz_cnt; s_start = start_cnt; s_done = done_cnt; s_rdv = rdv_cnt;
    ctx_base = ctx_wr_cnt;
    st_base = st_wr_cnt;
  endtask

  // One full run: cd>0 asserts i_complete cd cycles after o_start, cd<0 never completes.
  task automatic do_run(input int n, input int ins, input int k, input int tmo,
                        input bit ctx_tog, input bit rd_stall, input int cd, input bit early);
    int w;
    w = 1 << (n - 2);
    snap();
    r_beats = 0; r_data_bad = 0; r_last_bad = 0; r_stable_bad = 0; r_hung = 0;
    @(negedge clk);
    i_qbit_num = 6'(n); i_ins_num = 17'(ins); i_basis_idx = 18'(k); i_timeout = 32'(tmo);
    i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    fork
      begin : ctx_drv
        int sent, c;
        logic acc;
        sent = 0; c = 0;
        while (sent < ins && c < 4000) begin
          i_ctx_valid = ctx_tog ? ((c % 2) == 0) : 1'b1;
          i_ctx_data = ctx_word(sent);
          acc = i_ctx_valid && o_ctx_ready;
          @(negedge clk);
          if (acc) sent++;
          c++;
        end
        i_ctx_valid = 1'b0;
        if (sent < ins) r_hung = 1;
      end
      begin : cmp_drv
        int c;
        c = 0;
        while (!o_start && o_busy && c < 6000) begin
          @(negedge clk);
          c++;
        end
        if (o_start && cd > 0) begin
          for (int j = 0; j < cd && o_busy; j++) begin
            i_complete = (j == 0) && early;
            @(negedge clk);
          end
          i_complete = 1'b0;
          if (o_busy) begin
            bd_req = 1'b1;
            i_complete = 1'b1;
            @(negedge clk);
            bd_req = 1'b0;
            i_complete = 1'b0;
          end
        end
      end
      begin : rd_cons
        int c;
        logic [255:0] hd;
        logic hl, stalled;
        c = 0; stalled = 1'b0; hd = '0; hl = 1'b0;
        while (o_busy && c < 8000) begin
          i_rd_ready = rd_stall ? ((c % 4) == 3) : 1'b1;
          if (o_rd_valid) begin
            if (stalled && (o_rd_data !== hd || o_rd_last !== hl)) r_stable_bad++;
            if (i_rd_ready) begin
              if (o_rd_data !== qpat(r_beats)) r_data_bad++;
              if (o_rd_last !== (r_beats == w - 1)) r_last_bad++;
              r_beats++;
              stalled = 1'b0;
            end else begin
              stalled = 1'b1;
              hd = o_rd_data;
              hl = o_rd_last;
            end
          end
          @(negedge clk);
          c++;
        end
        i_rd_ready = 1'b0;
        if (o_busy) r_hung = 1;
      end
    join
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (any_out !== 1'b0) begin bad++; $display("FAIL reset_outputs: got %0b want 0", any_out); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_ctx_ready !== 1'b0) begin
      bad++; $display("FAIL reset_idle: busy=%0b ready=%0b want 0 0", o_busy, o_ctx_ready);
    end
  endtask

  task automatic test_bad_qbit();
    logic [5:0] nv [2];
    nv[0] = 6'd1; nv[1] = 6'd19;
    snap();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      i_qbit_num = nv[i]; i_ins_num = 17'd3; i_go = 1'b1;
      @(negedge clk);
      i_go = 1'b0;
      total++;
      if (o_err !== 2'd1 || o_busy !== 1'b0) begin
        bad++; $display("FAIL bad_qbit n=%0d: err=%0d busy=%0b want 1 0", nv[i], o_err, o_busy);
      end
    end
    repeat (10) @(negedge clk);
    total++;
    if (ctx_wr_cnt != s_ctx || st_wr_cnt != s_st || start_cnt != s_start) begin
      bad++; $display("FAIL bad_qbit_writes: ctx=%0d st=%0d start=%0d want 0 0 0",
                      ctx_wr_cnt - s_ctx, st_wr_cnt - s_st, start_cnt - s_start);
    end
  endtask

  task automatic test_load_basic();
    do_run(7, 433, 0, 0, 1'b0, 1'b0, 100, 1'b0);
    total++; if (r_hung != 0) begin bad++; $display("FAIL basic_hung: got %0d want 0", r_hung); end
    total++; if (ctx_wr_cnt - s_ctx != 433) begin
      bad++; $display("FAIL basic_ctx_count: got %0d want 433", ctx_wr_cnt - s_ctx); end
    total++; if (ctx_bad != s_ctxbad) begin
      bad++; $display("FAIL basic_ctx_data: bad writes %0d want 0", ctx_bad - s_ctxbad); end
    total++; if (ctx_last_cyc - ctx_first_cyc != 432) begin
      bad++; $display("FAIL basic_ctx_consecutive: span %0d want 432", ctx_last_cyc - ctx_first_cyc); end
    total++; if (st_wr_cnt - s_st != 32 || st_bad != s_stbad) begin
      bad++; $display("FAIL basic_state_writes: got %0d (bad addr %0d) want 32 (0)",
                      st_wr_cnt - s_st, st_bad - s_stbad); end
    total++; if (nz_cnt - s_nz != 1 || nz_addr !== 16'd0 || nz_data !== {One, 192'h0}) begin
      bad++; $display("FAIL basic_init_word: nz=%0d addr=%0d data=%h want 1 0 %h",
                      nz_cnt - s_nz, nz_addr, nz_data, {One, 192'h0}); end
    total++; if (start_cnt - s_start != 1) begin
      bad++; $display("FAIL basic_start: got %0d pulses want 1", start_cnt - s_start); end
    total++; if (o_run_cycles !== 32'd100) begin
      bad++; $display("FAIL basic_run_cycles: got %0d want 100", o_run_cycles); end
    total++; if (r_beats != 32 || r_data_bad != 0 || r_last_bad != 0) begin
      bad++; $display("FAIL basic_readback: beats=%0d databad=%0d lastbad=%0d want 32 0 0",
                      r_beats, r_data_bad, r_last_bad); end
    total++; if (done_cnt - s_done != 1 || o_err !== 2'd0) begin
      bad++; $display("FAIL basic_done: done=%0d err=%0d want 1 0", done_cnt - s_done, o_err); end
  endtask

  task automatic test_basis();
    // i_complete is also raised during the o_start cycle, which must not end the run.
    do_run(7, 0, 6, 0, 1'b0, 1'b0, 3, 1'b1);
    total++; if (nz_cnt - s_nz != 1 || nz_addr !== 16'd1 || nz_data !== {128'h0, One, 64'h0}) begin
      bad++; $display("FAIL basis6: nz=%0d addr=%0d data=%h want 1 1 %h",
                      nz_cnt - s_nz, nz_addr, nz_data, {128'h0, One, 64'h0}); end
    total++; if (o_run_cycles !== 32'd3 || r_beats != 32) begin
      bad++; $display("FAIL basis_early_complete: cycles=%0d beats=%0d want 3 32",
                      o_run_cycles, r_beats); end
    do_run(7, 0, 131, 0, 1'b0, 1'b0, 2, 1'b0);
    total++; if (nz_cnt - s_nz != 1 || nz_addr !== 16'd0 || nz_data !== {192'h0, One}) begin
      bad++; $display("FAIL basis_trunc: nz=%0d addr=%0d data=%h want 1 0 %h",
                      nz_cnt - s_nz, nz_addr, nz_data, {192'h0, One}); end
  endtask

  task automatic test_backpressure();
    do_run(7, 433, 0, 0, 1'b1, 1'b1, 20, 1'b0);
    total++; if (ctx_wr_cnt - s_ctx != 433 || ctx_bad != s_ctxbad || r_hung != 0) begin
      bad++; $display("FAIL bp_ctx: writes=%0d bad=%0d hung=%0d want 433 0 0",
                      ctx_wr_cnt - s_ctx, ctx_bad - s_ctxbad, r_hung); end
    total++; if (r_stable_bad != 0) begin
      bad++; $display("FAIL bp_stable: unstable stalls %0d want 0", r_stable_bad); end
    total++; if (r_beats != 32 || r_data_bad != 0 || r_last_bad != 0) begin
      bad++; $display("FAIL bp_readback: beats=%0d databad=%0d lastbad=%0d want 32 0 0",
                      r_beats, r_data_bad, r_last_bad); end
    total++; if (done_cnt - s_done != 1) begin
      bad++; $display("FAIL bp_done: got %0d want 1", done_cnt - s_done); end
  endtask

  task automatic test_timeout();
    do_run(7, 4, 0, 50, 1'b0, 1'b0, -1, 1'b0);
    total++; if (o_err !== 2'd2 || o_busy !== 1'b0 || r_hung != 0) begin
      bad++; $display("FAIL timeout_err: err=%0d busy=%0b hung=%0d want 2 0 0", o_err, o_busy, r_hung); end
    total++; if (o_run_cycles !== 32'd50 || err2_cyc - start_cyc != 50) begin
      bad++; $display("FAIL timeout_cycle: cycles=%0d at=%0d want 50 50",
                      o_run_cycles, err2_cyc - start_cyc); end
    total++; if (rdv_cnt != s_rdv || done_cnt != s_done) begin
      bad++; $display("FAIL timeout_no_read: rd_valid=%0d done=%0d want 0 0",
                      rdv_cnt - s_rdv, done_cnt - s_done); end
  endtask

  task automatic test_single_word();
    do_run(2, 0, 3, 0, 1'b0, 1'b0, 5, 1'b0);
    total++; if (st_wr_cnt - s_st != 1 || nz_addr !== 16'd0 || nz_data !== {192'h0, One}) begin
      bad++; $display("FAIL single_init: writes=%0d addr=%0d data=%h want 1 0 %h",
                      st_wr_cnt - s_st, nz_addr, nz_data, {192'h0, One}); end
    total++; if (r_beats != 1 || r_last_bad != 0 || r_data_bad != 0 || o_run_cycles !== 32'd5) begin
      bad++; $display("FAIL single_read: beats=%0d lastbad=%0d databad=%0d cycles=%0d want 1 0 0 5",
                      r_beats, r_last_bad, r_data_bad, o_run_cycles); end
  endtask

  task automatic test_reset_mid();
    int c;
    snap();
    @(negedge clk);
    i_qbit_num = 6'd7; i_ins_num = 17'd0; i_basis_idx = 18'd0; i_timeout = 32'd0; i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    c = 0;
    while (st_wr_cnt - s_st < 5 && c < 100) begin @(negedge clk); c++; end
    rst = 1'b1;
    @(negedge clk);
    total++; if (any_out !== 1'b0) begin bad++; $display("FAIL rst_load_state: got %0b want 0", any_out); end
    rst = 1'b0;
    snap();
    repeat (40) @(negedge clk);
    total++; if (st_wr_cnt != s_st || start_cnt != s_start) begin
      bad++; $display("FAIL rst_load_quiet: writes=%0d starts=%0d want 0 0",
                      st_wr_cnt - s_st, start_cnt - s_start); end

    i_go = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
    c = 0;
    while (!o_start && c < 200) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    i_complete = 1'b1;
    @(negedge clk);
    i_complete = 1'b0;
    c = 0;
    while (!o_rd_valid && c < 50) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    total++; if (o_rd_valid !== 1'b1) begin
      bad++; $display("FAIL rst_read_stalled: rd_valid=%0b want 1", o_rd_valid); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (any_out !== 1'b0) begin bad++; $display("FAIL rst_readback: got %0b want 0", any_out); end
    rst = 1'b0;
    snap();
    repeat (10) @(negedge clk);
    total++; if (rdv_cnt != s_rdv || o_busy !== 1'b0) begin
      bad++; $display("FAIL rst_read_quiet: rd_valid=%0d busy=%0b want 0 0", rdv_cnt - s_rdv, o_busy); end

    do_run(7, 10, 5, 0, 1'b0, 1'b1, 7, 1'b0);
    total++; if (r_hung != 0 || r_beats != 32 || r_data_bad != 0 || done_cnt - s_done != 1) begin
      bad++; $display("FAIL rst_rerun: hung=%0d beats=%0d databad=%0d done=%0d want 0 32 0 1",
                      r_hung, r_beats, r_data_bad, done_cnt - s_done); end
    total++; if (ctx_wr_cnt - s_ctx != 10 || ctx_bad != s_ctxbad || nz_addr !== 16'd1 ||
                 nz_data !== {64'h0, One, 128'h0}) begin
      bad++; $display("FAIL rst_rerun_load: ctx=%0d bad=%0d addr=%0d data=%h want 10 0 1 %h",
                      ctx_wr_cnt - s_ctx, ctx_bad - s_ctxbad, nz_addr, nz_data,
                      {64'h0, One, 128'h0}); end
  endtask

  initial begin
    test_reset();
    test_bad_qbit();
    test_load_basic();
    test_basis();
    test_backpressure();
    test_timeout();
    test_single_word();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
